// File: rtl/apb_uart_tx_arbiter_if.sv
// apb_uart_tx_arbiter_if
// Handshake bundle between the APB front-ends, the TX arbiter and the
// UART TX frame serializer. Three channels are grouped here:
//   req_*   : APB-side write/read requests
//   rsp_*   : read responses returned from the APB master port
//   frame_* : 56-bit frame offered to the serializer
// The slave modport is the arbiter's view of the bundle.
// The master modport is the view of the surrounding sources and the sink.

interface apb_uart_tx_arbiter_if;

    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_ready;

    logic        frame_valid;
    logic [55:0] frame_data;
    logic        frame_ready;

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        output rsp_ready,
        output frame_valid,
        output frame_data,
        input  frame_ready
    );

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        output rsp_valid,
        output rsp_rdata,
        input  rsp_ready,
        input  frame_valid,
        input  frame_data,
        output frame_ready
    );

endinterface

// File: rtl/apb_uart_tx_arbiter.sv
// apb_uart_tx_arbiter
// Shares the single UART TX frame path between APB-side requests
// (WREQ/RREQ) and returned read responses (RRES). A two-state FSM grants
// one source in IDLE, registers the 56-bit frame {type, addr, data} and
// holds it in SEND until the serializer accepts it. An outstanding-read
// counter keeps RREQs ineligible once MAX_RD_OUT reads are in flight.
//
// Optional feature macro: RSP_PRIORITY_EN
//   defined     : an eligible response always beats an eligible request
//   not defined : ties between the two sources alternate (round-robin)

module apb_uart_tx_arbiter #(
    parameter int MAX_RD_OUT = 2,
    parameter int CNT_W      = 4
) (
    input  logic                 clk_apb,
    input  logic                 rst_apb,
    apb_uart_tx_arbiter_if.slave bus,
    input  logic                 rd_done,
    output logic [CNT_W-1:0]     rd_outstanding,
    output logic                 rd_err,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_RD_OUT);
    localparam logic [7:0]       TYPE_WREQ = 8'h01;
    localparam logic [7:0]       TYPE_RREQ = 8'h02;
    localparam logic [7:0]       TYPE_RRES = 8'h03;

    // Encoding of the round-robin memory: which source won the last grant.
    localparam logic LG_REQ = 1'b0;
    localparam logic LG_RSP = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    logic               last_grant;
    logic               frame_valid_q;
    logic [55:0]        frame_data_q;
    logic [CNT_W-1:0]   rd_cnt;
    logic               rd_err_q;

    logic               req_elig;
    logic               rsp_elig;
    logic               pick_rsp;
    logic               grant_req;
    logic               grant_rsp;
    logic               rd_inc;
    logic [55:0]        req_frame;

    // Eligibility, arbitration decision and the grant pulses for this cycle.
    // Grants are also gated by the reset input so no ready pulse can escape
    // while the block is held in reset.
    always_comb begin
        req_elig = bus.req_valid && (bus.req_write || (rd_cnt < MAX_CNT));
        rsp_elig = bus.rsp_valid;
`ifdef RSP_PRIORITY_EN
        pick_rsp = rsp_elig;
`else
        pick_rsp = rsp_elig && (!req_elig || (last_grant == LG_REQ));
`endif
        grant_rsp = rst_apb && (state == IDLE) && pick_rsp;
        grant_req = rst_apb && (state == IDLE) && req_elig && !pick_rsp;
        rd_inc    = grant_req && !bus.req_write;
        req_frame = bus.req_write ? {TYPE_WREQ, bus.req_addr, bus.req_wdata}
                                  : {TYPE_RREQ, bus.req_addr, 32'h0000_0000};
    end

    assign bus.req_ready   = grant_req;
    assign bus.rsp_ready   = grant_rsp;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_data  = frame_data_q;
    assign rd_outstanding  = rd_cnt;
    assign rd_err          = rd_err_q;
    assign busy            = (state == SEND);

    // Grant/send FSM: capture the frame on a grant, hold it until accepted.
    always_ff @(posedge clk_apb or negedge rst_apb) begin
        if (!rst_apb) begin
            state         <= IDLE;
            last_grant    <= LG_REQ;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rsp) begin
                        frame_data_q  <= {TYPE_RRES, 16'h0000, bus.rsp_rdata};
                        frame_valid_q <= 1'b1;
                        last_grant    <= LG_RSP;
                        state         <= SEND;
                    end else if (grant_req) begin
                        frame_data_q  <= req_frame;
                        frame_valid_q <= 1'b1;
                        last_grant    <= LG_REQ;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (bus.frame_ready) begin
                        frame_valid_q <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    frame_valid_q <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Outstanding-read counter and the sticky underflow flag.
    always_ff @(posedge clk_apb or negedge rst_apb) begin
        if (!rst_apb) begin
            rd_cnt   <= '0;
            rd_err_q <= 1'b0;
        end else begin
            if (rd_inc && !rd_done) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end else if (!rd_inc && rd_done && (rd_cnt != '0)) begin
                rd_cnt <= rd_cnt - CNT_W'(1);
            end
            if (rd_done && (rd_cnt == '0)) begin
                rd_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_tx_arbiter.sv
// tb_apb_uart_tx_arbiter
// Directed testbench for apb_uart_tx_arbiter (MAX_RD_OUT = 2, CNT_W = 4).
// Inputs are driven just after the falling edge; combinational ready pulses
// and registered outputs are sampled 1 time unit later, away from the
// rising (active) edge.

module tb_apb_uart_tx_arbiter;

    logic       clk_apb;
    logic       rst_apb;
    logic       rd_done;
    logic [3:0] rd_outstanding;
    logic       rd_err;
    logic       busy;

    int tests_run;
    int tests_failed;

    apb_uart_tx_arbiter_if bus_if ();

    apb_uart_tx_arbiter #(
        .MAX_RD_OUT (2),
        .CNT_W      (4)
    ) dut (
        .clk_apb        (clk_apb),
        .rst_apb        (rst_apb),
        .bus            (bus_if),
        .rd_done        (rd_done),
        .rd_outstanding (rd_outstanding),
        .rd_err         (rd_err),
        .busy           (busy)
    );

    initial clk_apb = 1'b0;
    always #5 clk_apb = ~clk_apb;

    task automatic clear_inputs();
        bus_if.req_valid   = 1'b0;
        bus_if.req_write   = 1'b0;
        bus_if.req_addr    = 16'h0000;
        bus_if.req_wdata   = 32'h0000_0000;
        bus_if.rsp_valid   = 1'b0;
        bus_if.rsp_rdata   = 32'h0000_0000;
        bus_if.frame_ready = 1'b0;
        rd_done            = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_apb);
        rst_apb = 1'b0;
        clear_inputs();
        @(negedge clk_apb);
        @(negedge clk_apb);
        rst_apb = 1'b1;
    endtask

    task automatic test_reset();
        rst_apb = 1'b0;
        clear_inputs();
        bus_if.req_valid   = 1'b1;
        bus_if.req_write   = 1'b1;
        bus_if.rsp_valid   = 1'b1;
        bus_if.frame_ready = 1'b1;
        repeat (2) @(negedge clk_apb);
        #1;
        tests_run++; if (bus_if.req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b want 0", bus_if.req_ready); end
        tests_run++; if (bus_if.rsp_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_ready: got %b want 0", bus_if.rsp_ready); end
        tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_valid: got %b want 0", bus_if.frame_valid); end
        tests_run++; if (bus_if.frame_data !== 56'h0) begin tests_failed++; $display("[TB] FAIL reset_frame_data: got %h want 0", bus_if.frame_data); end
        tests_run++; if (rd_outstanding !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_rd_outstanding: got %0d want 0", rd_outstanding); end
        tests_run++; if (rd_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_err: got %b want 0", rd_err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        clear_inputs();
        @(negedge clk_apb);
        rst_apb = 1'b1;
        @(negedge clk_apb);
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_release_idle: got %b want 0", bus_if.frame_valid); end
    endtask

    task automatic test_wreq();
        do_reset();
        @(negedge clk_apb);
        bus_if.req_valid   = 1'b1;
        bus_if.req_write   = 1'b1;
        bus_if.req_addr    = 16'hBBBB;
        bus_if.req_wdata   = 32'hAAAA_AAAA;
        bus_if.frame_ready = 1'b1;
        #1;
        tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL wreq_ready_pulse: got %b want 1", bus_if.req_ready); end
        tests_run++; if (bus_if.rsp_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL wreq_rsp_ready: got %b want 0", bus_if.rsp_ready); end
        tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wreq_valid_early: got %b want 0", bus_if.frame_valid); end
        @(negedge clk_apb);
        bus_if.req_valid = 1'b0;
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL wreq_frame_valid: got %b want 1", bus_if.frame_valid); end
        tests_run++; if (bus_if.frame_data !== 56'h01BBBBAAAAAAAA) begin tests_failed++; $display("[TB] FAIL wreq_frame_data: got %h want 01bbbbaaaaaaaa", bus_if.frame_data); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL wreq_busy: got %b want 1", busy); end
        tests_run++; if (bus_if.req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL wreq_single_pulse: got %b want 0", bus_if.req_ready); end
        @(negedge clk_apb);
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wreq_valid_one_cycle: got %b want 0", bus_if.frame_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL wreq_busy_done: got %b want 0", busy); end
        tests_run++; if (rd_outstanding !== 4'd0) begin tests_failed++; $display("[TB] FAIL wreq_rd_outstanding: got %0d want 0", rd_outstanding); end
        bus_if.frame_ready = 1'b0;
    endtask

    task automatic test_rreq_limit();
        do_reset();
        @(negedge clk_apb);
        bus_if.req_valid   = 1'b1;
        bus_if.req_write   = 1'b0;
        bus_if.req_addr    = 16'h1212;
        bus_if.req_wdata   = 32'hFFFF_FFFF;
        bus_if.frame_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rreq_grant_%0d: got %b want 1", k, bus_if.req_ready); end
            @(negedge clk_apb);
            #1;
            tests_run++; if (bus_if.frame_data !== 56'h021212_00000000) begin tests_failed++; $display("[TB] FAIL rreq_frame_%0d: got %h want 02121200000000", k, bus_if.frame_data); end
            tests_run++; if (bus_if.frame_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rreq_valid_%0d: got %b want 1", k, bus_if.frame_valid); end
            tests_run++; if (rd_outstanding !== 4'(k + 1)) begin tests_failed++; $display("[TB] FAIL rreq_count_%0d: got %0d want %0d", k, rd_outstanding, k + 1); end
            @(negedge clk_apb);
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++; if (bus_if.req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rreq_stall_ready_%0d: got %b want 0", k, bus_if.req_ready); end
            tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rreq_stall_valid_%0d: got %b want 0", k, bus_if.frame_valid); end
            @(negedge clk_apb);
            #1;
        end
        rd_done = 1'b1;
        #1;
        tests_run++; if (bus_if.req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rreq_done_cycle_ready: got %b want 0", bus_if.req_ready); end
        @(negedge clk_apb);
        rd_done = 1'b0;
        #1;
        tests_run++; if (rd_outstanding !== 4'd1) begin tests_failed++; $display("[TB] FAIL rreq_after_done_count: got %0d want 1", rd_outstanding); end
        tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rreq_released: got %b want 1", bus_if.req_ready); end
        @(negedge clk_apb);
        bus_if.req_valid = 1'b0;
        #1;
        tests_run++; if (bus_if.frame_data !== 56'h021212_00000000) begin tests_failed++; $display("[TB] FAIL rreq_third_frame: got %h want 02121200000000", bus_if.frame_data); end
        tests_run++; if (rd_outstanding !== 4'd2) begin tests_failed++; $display("[TB] FAIL rreq_count_back_2: got %0d want 2", rd_outstanding); end
        @(negedge clk_apb);
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rreq_third_done: got %b want 0", bus_if.frame_valid); end
        bus_if.frame_ready = 1'b0;
    endtask

    task automatic test_tie();
        logic exp_rsp;
        do_reset();
        @(negedge clk_apb);
        bus_if.rsp_valid   = 1'b1;
        bus_if.rsp_rdata   = 32'hCCCC_CCCC;
        bus_if.req_valid   = 1'b1;
        bus_if.req_write   = 1'b1;
        bus_if.req_addr    = 16'hDDDD;
        bus_if.req_wdata   = 32'h5555_5555;
        bus_if.frame_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef RSP_PRIORITY_EN
            exp_rsp = 1'b1;
`else
            exp_rsp = ((k % 2) == 0);
`endif
            tests_run++; if (bus_if.rsp_ready !== exp_rsp) begin tests_failed++; $display("[TB] FAIL tie_rsp_ready_%0d: got %b want %b", k, bus_if.rsp_ready, exp_rsp); end
            tests_run++; if (bus_if.req_ready !== !exp_rsp) begin tests_failed++; $display("[TB] FAIL tie_req_ready_%0d: got %b want %b", k, bus_if.req_ready, !exp_rsp); end
            @(negedge clk_apb);
            #1;
            if (exp_rsp) begin
                tests_run++; if (bus_if.frame_data !== 56'h030000CCCCCCCC) begin tests_failed++; $display("[TB] FAIL tie_frame_%0d: got %h want 030000cccccccc", k, bus_if.frame_data); end
            end else begin
                tests_run++; if (bus_if.frame_data !== 56'h01DDDD55555555) begin tests_failed++; $display("[TB] FAIL tie_frame_%0d: got %h want 01dddd55555555", k, bus_if.frame_data); end
            end
            tests_run++; if (bus_if.frame_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL tie_valid_%0d: got %b want 1", k, bus_if.frame_valid); end
            @(negedge clk_apb);
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk_apb);
        bus_if.req_valid   = 1'b1;
        bus_if.req_write   = 1'b1;
        bus_if.req_addr    = 16'h1234;
        bus_if.req_wdata   = 32'hDEAD_BEEF;
        bus_if.frame_ready = 1'b0;
        #1;
        tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_grant: got %b want 1", bus_if.req_ready); end
        @(negedge clk_apb);
        bus_if.req_addr  = 16'h5678;
        bus_if.req_wdata = 32'h0000_0001;
        bus_if.rsp_valid = 1'b1;
        bus_if.rsp_rdata = 32'h0000_0002;
        #1;
        for (int k = 0; k < 10; k++) begin
            tests_run++; if (bus_if.frame_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_valid_%0d: got %b want 1", k, bus_if.frame_valid); end
            tests_run++; if (bus_if.frame_data !== 56'h011234DEADBEEF) begin tests_failed++; $display("[TB] FAIL bp_data_%0d: got %h want 011234deadbeef", k, bus_if.frame_data); end
            tests_run++; if ((bus_if.req_ready | bus_if.rsp_ready) !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_no_ready_%0d: got req %b rsp %b want 0 0", k, bus_if.req_ready, bus_if.rsp_ready); end
            tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_busy_%0d: got %b want 1", k, busy); end
            @(negedge clk_apb);
            #1;
        end
        bus_if.req_valid   = 1'b0;
        bus_if.rsp_valid   = 1'b0;
        bus_if.frame_ready = 1'b1;
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_accept_cycle: got %b want 1", bus_if.frame_valid); end
        @(negedge clk_apb);
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_done_valid: got %b want 0", bus_if.frame_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_done_busy: got %b want 0", busy); end
        bus_if.frame_ready = 1'b0;
    endtask

    task automatic test_counter_corners();
        do_reset();
        @(negedge clk_apb);
        rd_done = 1'b1;
        @(negedge clk_apb);
        rd_done = 1'b0;
        #1;
        tests_run++; if (rd_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL cnt_err_set: got %b want 1", rd_err); end
        tests_run++; if (rd_outstanding !== 4'd0) begin tests_failed++; $display("[TB] FAIL cnt_stays_zero: got %0d want 0", rd_outstanding); end
        @(negedge clk_apb);
        bus_if.req_valid   = 1'b1;
        bus_if.req_write   = 1'b0;
        bus_if.req_addr    = 16'h0001;
        bus_if.frame_ready = 1'b1;
        #1;
        tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL cnt_first_rreq: got %b want 1", bus_if.req_ready); end
        @(negedge clk_apb);
        bus_if.req_valid = 1'b0;
        #1;
        tests_run++; if (rd_outstanding !== 4'd1) begin tests_failed++; $display("[TB] FAIL cnt_one: got %0d want 1", rd_outstanding); end
        @(negedge clk_apb);
        bus_if.req_valid = 1'b1;
        rd_done          = 1'b1;
        #1;
        tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL cnt_same_cycle_grant: got %b want 1", bus_if.req_ready); end
        @(negedge clk_apb);
        bus_if.req_valid = 1'b0;
        rd_done          = 1'b0;
        #1;
        tests_run++; if (rd_outstanding !== 4'd1) begin tests_failed++; $display("[TB] FAIL cnt_same_cycle: got %0d want 1", rd_outstanding); end
        tests_run++; if (rd_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL cnt_err_sticky: got %b want 1", rd_err); end
        @(negedge clk_apb);
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL cnt_frame_done: got %b want 0", bus_if.frame_valid); end
        bus_if.frame_ready = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        @(negedge clk_apb);
        bus_if.req_valid   = 1'b1;
        bus_if.req_write   = 1'b0;
        bus_if.req_addr    = 16'h4321;
        bus_if.frame_ready = 1'b0;
        #1;
        tests_run++; if (bus_if.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_grant: got %b want 1", bus_if.req_ready); end
        @(negedge clk_apb);
        bus_if.req_valid = 1'b0;
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_valid_before: got %b want 1", bus_if.frame_valid); end
        tests_run++; if (rd_outstanding !== 4'd1) begin tests_failed++; $display("[TB] FAIL mid_count_before: got %0d want 1", rd_outstanding); end
        #1;
        rst_apb = 1'b0;
        #1;
        tests_run++; if (bus_if.frame_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_async_valid: got %b want 0", bus_if.frame_valid); end
        tests_run++; if (bus_if.frame_data !== 56'h0) begin tests_failed++; $display("[TB] FAIL mid_async_data: got %h want 0", bus_if.frame_data); end
        tests_run++; if (rd_outstanding !== 4'd0) begin tests_failed++; $display("[TB] FAIL mid_async_count: got %0d want 0", rd_outstanding); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_async_busy: got %b want 0", busy); end
        @(negedge clk_apb);
        rst_apb            = 1'b1;
        bus_if.frame_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_apb);
            #1;
            tests_run++; if ((bus_if.frame_valid | busy) !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_no_frame_%0d: got valid %b busy %b want 0 0", k, bus_if.frame_valid, busy); end
        end
        bus_if.frame_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_apb      = 1'b0;
        clear_inputs();
        test_reset();
        test_wreq();
        test_rreq_limit();
        test_tie();
        test_backpressure();
        test_counter_corners();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_uart_tx_arbiter.md
# apb_uart_tx_arbiter

- Shares the bridge's single UART transmit frame path between two sources:
  - APB-side requests (write and read requests captured from the APB slave port).
  - Read responses (returned from the APB master port).
- Builds the 56-bit frame `{type[7:0], addr[15:0], data[31:0]}` and hands it to the TX serializer over a valid/ready handshake.
- Limits how many read requests can be in flight at once.
- Sits in the APB clock domain, between the APB slave/master front-ends and the UART TX frame serializer.

## Interface

Parameters:
- `MAX_RD_OUT`, default 2: maximum number of issued RREQ frames still awaiting their RRES (range 1..15).
- `CNT_W`, default 4: width of the outstanding-read counter.

Ports:
- `clk_apb`  in  1  block clock.
- `rst_apb`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  APB-side request pending.
- `req_write`  in  1  1 = WREQ, 0 = RREQ.
- `req_addr`  in  16  request address.
- `req_wdata`  in  32  write data; ignored for RREQ.
- `req_ready`  out  1  one-cycle accept pulse for the request.
- `rsp_valid`  in  1  read response pending.
- `rsp_rdata`  in  32  read response data.
- `rsp_ready`  out  1  one-cycle accept pulse for the response.
- `frame_valid`  out  1  frame offered to the serializer.
- `frame_data`  out  56  frame contents.
- `frame_ready`  in  1  serializer accepts the frame.
- `rd_done`  in  1  one-cycle pulse from the RX decoder when an RRES frame arrives from the far end.
- `rd_outstanding`  out  CNT_W  current count of in-flight reads.
- `rd_err`  out  1  sticky flag: `rd_done` arrived while the count was 0.
- `busy`  out  1  FSM is not in IDLE.

## Operation

- FSM has two states, IDLE and SEND.
- Eligibility:
  - Request is eligible when `req_valid` is high and either `req_write` = 1, or `req_write` = 0 and `rd_outstanding < MAX_RD_OUT`.
  - Response is eligible when `rsp_valid` is high.
- IDLE:
  - If neither source is eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the source not granted last (round-robin). `last_grant` is 1 bit and updates on every grant.
  - On a grant: pulse the granted source's ready for this cycle, register the frame, go to SEND.
- Frame encoding:
  - WREQ = `{8'h01, req_addr, req_wdata}`.
  - RREQ = `{8'h02, req_addr, 32'h0}`.
  - RRES = `{8'h03, 16'h0000, rsp_rdata}`.
- SEND:
  - `frame_valid` is 1 and `frame_data` holds stable.
  - On `frame_ready` = 1: return to IDLE and drop `frame_valid` the next cycle.
  - A request for the next frame is not evaluated until IDLE.
- Outstanding-read counter:
  - Increments when an RREQ is granted.
  - Decrements on `rd_done`.
  - Both in the same cycle: unchanged.
  - `rd_done` at 0: count stays 0 and `rd_err` is set.
  - The counter saturates and never exceeds `MAX_RD_OUT`, because RREQ is ineligible at the limit.
- A WREQ is never blocked by the read limit. At the limit, a pending RREQ stalls while responses still flow.
- Sources must hold valid and payload stable until they see ready. The block captures payload only in the grant cycle.

## Timing

- Reset values (all outputs): `req_ready` 0, `rsp_ready` 0, `frame_valid` 0, `frame_data` 0, `rd_outstanding` 0, `rd_err` 0, `busy` 0; FSM in IDLE; `last_grant` = request, so the first tie goes to the response.
- Reset asserted mid-SEND: `frame_valid` drops asynchronously, the captured frame is discarded, and the counter clears.
- Latency:
  - Valid high in IDLE at cycle N gives the ready pulse in cycle N and `frame_valid` = 1 from N+1.
  - With `frame_ready` tied high, `frame_valid` is 1 for exactly one cycle. The next grant can happen at N+2.
  - Peak throughput is one frame per 2 cycles.
- `rd_outstanding` updates one cycle after the grant or `rd_done` edge.
- `busy` = 1 from N+1 until the cycle after the frame is accepted.

## Configuration

- Macro: `RSP_PRIORITY_EN`.
- Defined: an eligible response always wins over an eligible request (strict priority), so read latency on the far side stays bounded. `last_grant` is still maintained but not used for the decision.
- Not defined: round-robin as described in Operation.

## Test plan

- WREQ: `req_write` = 1, addr `16'hBBBB`, data `32'hAAAAAAAA` → `req_ready` pulses once; `frame_data` = `56'h01BBBBAAAAAAAA` with `frame_valid` for 1 cycle (`frame_ready` high); `rd_outstanding` stays 0.
- RREQ limit: 3 RREQs to addr `16'h1212` with `MAX_RD_OUT` = 2 and no `rd_done` → two `56'h021212_00000000` frames are sent, the third stalls with `req_ready` low; one `rd_done` pulse releases it and the count returns to 2.
- Tie: `rsp_valid` with `32'hCCCCCCCC` and a WREQ to `16'hDDDD` / `32'h55555555` raised together after reset → RRES frame `56'h030000CCCCCCCC` goes first, then `56'h01DDDD55555555`. With `RSP_PRIORITY_EN` and a response continuously valid, the request never wins.
- Backpressure: `frame_ready` held low for 10 cycles in SEND → `frame_valid` and `frame_data` stay stable and no ready pulse occurs; raising `frame_ready` completes the transfer.
- Counter corner cases: `rd_done` at count 0 → `rd_err` = 1 and stays set until reset. RREQ grant and `rd_done` in the same cycle at count 1 → count stays 1.
- Reset mid-SEND: assert `rst_apb` low while `frame_valid` = 1 → all outputs go to 0 immediately, and no frame is emitted after release until a new valid arrives.
